exe_mul_sequencer: RTL and testbench

- Multi-cycle multiply/multiply-accumulate controller attached to the execute stage of the pipelined ARM core.
- While a MUL/MLA instruction occupies EXE, it freezes the pipeline and runs an iterative radix-2 shift-add multiply.
- It then presents the result and NZCV status update to the EXE/MEM boundary and releases the freeze for exactly one completion cycle.

---
 rtl/exe_mul_sequencer.sv | 119 +++++++++++
 tb/tb_exe_mul_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/exe_mul_sequencer.sv
// rtl/exe_mul_sequencer.sv - iterative radix-2 MUL/MLA sequencer for the execute stage
module exe_mul_sequencer #(
    parameter int N     = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic             s_in,
    input  logic             acc_en,
    input  logic [N-1:0]     val_rm,
    input  logic [N-1:0]     val_rs,
    input  logic [N-1:0]     acc_val,
    input  logic [3:0]       status_in,
    output logic             freeze,
    output logic             done,
    output logic [N-1:0]     result,
    output logic             status_we,
    output logic [3:0]       status_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [N-1:0]     result_q, result_d;
    logic             s_lat_q, s_lat_d;

    // State and datapath registers; reset clears everything so no partial product leaks out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            s_lat_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            s_lat_q  <= s_lat_d;
        end
    end

    // Next-state, shift-add step and control outputs.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        result_d  = result_q;
        s_lat_d   = s_lat_q;
        freeze    = 1'b0;
        done      = 1'b0;
        status_we = 1'b0;
        case (state_q)
            IDLE: begin
                // Hold the pipeline in the acceptance cycle itself; flush wins over start.
                freeze = start & ~flush;
                if (start && !flush) begin
                    mcand_d  = val_rm;
                    mplier_d = val_rs;
                    acc_d    = acc_en ? acc_val : '0;
                    s_lat_d  = s_in;
                    count_d  = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                freeze = 1'b1;
                if (flush) begin
                    // Aborted operation: the held result is left untouched.
                    state_d = IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + 1'b1;
                    if (count_q == CNT_W'(N - 1)) begin
                        result_d = acc_d;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                // start is still the same instruction here, so it is never re-accepted.
                done      = 1'b1;
                status_we = s_lat_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result = result_q;

    // N and Z come from the held result; C and V pass through. Forced to zero while in reset.
    assign status_out = rst ? 4'b0000
                            : {result_q[N-1], (result_q == '0), status_in[1], status_in[0]};

endmodule

// File: tb/tb_exe_mul_sequencer.sv
// tb/tb_exe_mul_sequencer.sv - directed self-checking bench for exe_mul_sequencer
module tb_exe_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic        s_in;
    logic        acc_en;
    logic [31:0] val_rm;
    logic [31:0] val_rs;
    logic [31:0] acc_val;
    logic [3:0]  status_in;
    logic        freeze;
    logic        done;
    logic [31:0] result;
    logic        status_we;
    logic [3:0]  status_out;

    int tests = 0;
    int fails = 0;

    exe_mul_sequencer #(.N(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .flush      (flush),
        .s_in       (s_in),
        .acc_en     (acc_en),
        .val_rm     (val_rm),
        .val_rs     (val_rs),
        .acc_val    (acc_val),
        .status_in  (status_in),
        .freeze     (freeze),
        .done       (done),
        .result     (result),
        .status_we  (status_we),
        .status_out (status_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one operation, hold start through DONE, then release start for one idle cycle.
    task automatic do_op(input string tag, input logic [31:0] rm, input logic [31:0] rs,
                         input logic ae, input logic [31:0] av, input logic s,
                         input logic [3:0] st, input logic [31:0] exp_res,
                         input logic [3:0] exp_st, input logic exp_we);
        int   cyc;
        int   fcnt;
        logic got;
        logic we_bad;
        @(posedge clk); #1;
        val_rm = rm; val_rs = rs; acc_en = ae; acc_val = av; s_in = s; status_in = st;
        flush = 1'b0; start = 1'b1;
        @(negedge clk);
        check({tag, " accept_freeze"}, 32'(freeze), 32'd1);
        fcnt   = 1;
        cyc    = 0;
        got    = 1'b0;
        we_bad = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (freeze) fcnt++;
            if (status_we && !done) we_bad = 1'b1;
            if (done) begin
                got = 1'b1;
                check({tag, " result"}, result, exp_res);
                check({tag, " status_out"}, 32'(status_out), 32'(exp_st));
                check({tag, " status_we"}, 32'(status_we), 32'(exp_we));
                check({tag, " done_freeze"}, 32'(freeze), 32'd0);
            end
        end
        check({tag, " done_cycle"}, 32'(cyc), 32'd33);
        check({tag, " freeze_cycles"}, 32'(fcnt), 32'd33);
        check({tag, " we_outside_done"}, 32'(we_bad), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, " post_done"}, 32'(done), 32'd0);
        check({tag, " post_freeze"}, 32'(freeze), 32'd0);
        check({tag, " post_result"}, result, exp_res);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; s_in = 1'b0; acc_en = 1'b0;
        val_rm = '0; val_rs = '0; acc_val = '0; status_in = 4'b0000;
        #12;
        check("rst freeze", 32'(freeze), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", result, 32'd0);
        check("rst status_we", 32'(status_we), 32'd0);
        check("rst status_out", 32'(status_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic MUL, accumulate operand ignored when acc_en=0.
        do_op("mul3x5", 32'd3, 32'd5, 1'b0, 32'd99, 1'b1, 4'b0011, 32'd15, 4'b0011, 1'b1);
        // MLA wrapping to all ones: N=1, Z=0.
        do_op("mla_wrap", 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd1, 1'b1, 4'b0000,
              32'hFFFF_FFFF, 4'b1000, 1'b1);

        // Flush at BUSY cycle 10: abort, result keeps previous value.
        @(posedge clk); #1;
        val_rm = 32'd9; val_rs = 32'd9; acc_en = 1'b0; s_in = 1'b1; start = 1'b1;
        for (int i = 0; i < 10; i++) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush busy_freeze", 32'(freeze), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check("flush idle_freeze", 32'(freeze), 32'd0);
        check("flush result", result, 32'hFFFF_FFFF);
        begin
            logic any_done;
            any_done = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done || status_we) any_done = 1'b1;
            end
            check("flush no_done", 32'(any_done), 32'd0);
        end

        // Zero product with S=0.
        do_op("zero_s0", 32'd0, 32'd1234, 1'b0, 32'd0, 1'b0, 4'b0001, 32'd0, 4'b0101, 1'b0);

        // Asynchronous reset between edges at BUSY cycle 20.
        do_op("pre_rst", 32'd4, 32'd5, 1'b0, 32'd0, 1'b0, 4'b0000, 32'd20, 4'b0000, 1'b0);
        @(posedge clk); #1;
        val_rm = 32'd11; val_rs = 32'd13; start = 1'b1;
        for (int i = 0; i < 20; i++) @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("midbusy freeze", 32'(freeze), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async freeze", 32'(freeze), 32'd0);
        check("async done", 32'(done), 32'd0);
        check("async result", result, 32'd0);
        rst = 1'b0;
        do_op("mul7x6", 32'd7, 32'd6, 1'b0, 32'd0, 1'b1, 4'b0000, 32'd42, 4'b0000, 1'b1);

        // Back-to-back: start held through DONE, one idle cycle, then a new operation.
        do_op("b2b_first", 32'd2, 32'd3, 1'b0, 32'd0, 1'b1, 4'b0010, 32'd6, 4'b0010, 1'b1);
        do_op("b2b_second", 32'd10, 32'd10, 1'b0, 32'd0, 1'b1, 4'b0010, 32'd100, 4'b0010, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
